// File: rtl/apbdma_apb_wr_backend.sv
// Write-side backend of the APB DMA: turns each midend write beat into one APB4 write
// transfer at an incrementing destination address, for a programmed number of beats.
module apbdma_apb_wr_backend #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int StrbWidth = DataWidth / 8,
    parameter int LenWidth  = 16
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 start_i,
    input  logic [AddrWidth-1:0] dst_addr_i,
    input  logic [LenWidth-1:0]  len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    input  logic [DataWidth-1:0] w_data_i,
    input  logic [StrbWidth-1:0] w_strb_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    output logic [AddrWidth-1:0] paddr_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [DataWidth-1:0] pwdata_o,
    output logic [StrbWidth-1:0] pstrb_o,
    output logic [2:0]           pprot_o,
    input  logic                 pready_i,
    input  logic                 pslverr_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BEAT,
        S_SETUP,
        S_ACCESS,
        S_FINISH
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [AddrWidth-1:0] r_addr;
    logic [AddrWidth-1:0] r_paddr;
    logic [LenWidth-1:0]  r_count;
    logic [DataWidth-1:0] r_data;
    logic [StrbWidth-1:0] r_strb;
    logic                 r_err;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        w_ready_o    = 1'b0;
        psel_o       = 1'b0;
        penable_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_next = (len_i == '0) ? S_FINISH : S_WAIT_BEAT;
                end
            end
            S_WAIT_BEAT: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                psel_o       = 1'b1;
                w_state_next = S_ACCESS;
            end
            S_ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (pready_i) begin
                    if (pslverr_i || (r_count == LenWidth'(1))) begin
                        w_state_next = S_FINISH;
                    end else begin
                        w_state_next = S_WAIT_BEAT;
                    end
                end
            end
            S_FINISH: begin
                done_o       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The APB-facing address/data/strobe registers load only on a beat capture, so
    // they hold their last transfer's values while the bus is idle.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_addr  <= '0;
            r_paddr <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_strb  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_addr  <= dst_addr_i;
                        r_count <= len_i;
                        r_err   <= 1'b0;
                    end
                end
                S_WAIT_BEAT: begin
                    if (w_valid_i) begin
                        r_data  <= w_data_i;
                        r_strb  <= w_strb_i;
                        r_paddr <= r_addr;
                    end
                end
                S_ACCESS: begin
                    if (pready_i) begin
                        if (pslverr_i) begin
                            r_err <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + AddrWidth'(StrbWidth);
                            r_count <= r_count - LenWidth'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign err_o    = r_err;
    assign paddr_o  = r_paddr;
    assign pwdata_o = r_data;
    assign pstrb_o  = r_strb;
    assign pwrite_o = psel_o;
    assign pprot_o  = 3'b000;

endmodule

// File: tb/tb_apbdma_apb_wr_backend.sv
// Scoreboard bench for apbdma_apb_wr_backend: expected APB transfers and completion
// status are queued at stimulus time and checked by a monitor as the DUT produces them.
module tb_apbdma_apb_wr_backend;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, err_o;
    logic [31:0] w_data_i;
    logic [3:0]  w_strb_i;
    logic        w_valid_i;
    logic        w_ready_o;
    logic [31:0] paddr_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [2:0]  pprot_o;
    logic        pready_i, pslverr_i;

    apbdma_apb_wr_backend dut (
        .pclk       (pclk),
        .preset     (preset),
        .start_i    (start_i),
        .dst_addr_i (dst_addr_i),
        .len_i      (len_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .w_data_i   (w_data_i),
        .w_strb_i   (w_strb_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .paddr_o    (paddr_o),
        .psel_o     (psel_o),
        .penable_o  (penable_o),
        .pwrite_o   (pwrite_o),
        .pwdata_o   (pwdata_o),
        .pstrb_o    (pstrb_o),
        .pprot_o    (pprot_o),
        .pready_i   (pready_i),
        .pslverr_i  (pslverr_i)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t beat_q[$];
    logic  exp_err_q[$];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int psel_cycles = 0;
    int ready_cycles = 0;
    int consumed = 0;
    int wait_cfg = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // APB slave: wait_cfg wait states per access, error on err_addr when enabled.
    initial begin
        int wcnt;
        wcnt = 0;
        pready_i = 1'b0;
        pslverr_i = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            if (psel_o && penable_o) begin
                if (wcnt < wait_cfg) begin
                    pready_i = 1'b0;
                    pslverr_i = 1'b0;
                    wcnt++;
                end else begin
                    pready_i = 1'b1;
                    pslverr_i = err_en && (paddr_o == err_addr);
                end
            end else begin
                pready_i = 1'b0;
                pslverr_i = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Beat source: presents the head of beat_q, pops on handshake.
    initial begin
        logic hs;
        w_valid_i = 1'b0;
        w_data_i = '0;
        w_strb_i = '0;
        forever begin
            @(negedge pclk);
            hs = w_valid_i && w_ready_o && !preset;
            @(posedge pclk);
            #1;
            if (hs && beat_q.size() > 0) begin
                beat_q.delete(0);
                consumed++;
            end
            if (beat_q.size() > 0) begin
                w_valid_i = 1'b1;
                w_data_i = beat_q[0].data;
                w_strb_i = beat_q[0].strb;
            end else begin
                w_valid_i = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    logic        hold_v = 1'b0;
    logic [31:0] hold_addr, hold_data;
    xfer_t       mon_e;
    always @(negedge pclk) begin
        if (!preset) begin
            if (psel_o) psel_cycles++;
            if (w_ready_o) ready_cycles++;
            if (hold_v && psel_o) begin
                check("hold_paddr", 64'(paddr_o), 64'(hold_addr));
                check("hold_pwdata", 64'(pwdata_o), 64'(hold_data));
                check("hold_penable", 64'(penable_o), 64'd1);
            end
            hold_v = psel_o && penable_o && !pready_i;
            hold_addr = paddr_o;
            hold_data = pwdata_o;
            if (psel_o && penable_o && pready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_xfer actual=%0h required=none", paddr_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("paddr", 64'(paddr_o), 64'(mon_e.addr));
                    check("pwdata", 64'(pwdata_o), 64'(mon_e.data));
                    check("pstrb", 64'(pstrb_o), 64'(mon_e.strb));
                    check("pwrite_pprot", {63'(pprot_o), pwrite_o}, 64'd1);
                end
            end
            if (done_o) begin
                done_cnt++;
                if (exp_err_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    check("done_err", 64'(err_o), 64'(exp_err_q.pop_front()));
                    check("done_busy", 64'(busy_o), 64'd1);
                end
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    task automatic do_start(input logic [31:0] addr, input logic [15:0] len);
        @(posedge pclk);
        #2;
        dst_addr_i = addr;
        len_i = len;
        start_i = 1'b1;
        @(posedge pclk);
        #2;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int base, output int cycles);
        cycles = 0;
        while (done_cnt == base && cycles < 300) begin
            @(posedge pclk);
            cycles++;
        end
        if (done_cnt == base) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done");
        end
    endtask

    // Queue beats/expectations, start, wait for done and check consumption.
    task automatic run_xfer(input string name, input logic [31:0] addr, input int len,
                            input logic [31:0] dbase, input logic [3:0] strb0,
                            input int waits, input int err_idx);
        xfer_t b;
        int c0, base, cyc, ncons;
        ncons = len;
        for (int i = 0; i < len; i++) begin
            b.addr = addr + 32'(4 * i);
            b.data = dbase + 32'(i * 32'h0101_0101);
            b.strb = (i == 0) ? strb0 : 4'hF;
            beat_q.push_back(b);
            if (err_idx < 0 || i <= err_idx) exp_q.push_back(b);
        end
        if (err_idx >= 0) ncons = err_idx + 1;
        exp_err_q.push_back(err_idx >= 0);
        wait_cfg = waits;
        err_en = (err_idx >= 0);
        err_addr = addr + 32'(4 * err_idx);
        c0 = consumed;
        base = done_cnt;
        do_start(addr, 16'(len));
        wait_done(base, cyc);
        repeat (2) @(posedge pclk);
        #2;
        check({name, "_xfers_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_consumed"}, 64'(consumed - c0), 64'(ncons));
        check({name, "_done_once"}, 64'(done_cnt - base), 64'd1);
        check({name, "_idle"}, 64'(busy_o), 64'd0);
        beat_q.delete();
        exp_q.delete();
        err_en = 1'b0;
        wait_cfg = 0;
        $display("%s: addr=%0h len=%0d waits=%0d err_idx=%0d err_o=%0d", name, addr, len, waits, err_idx, err_o);
    endtask

    initial begin
        int base, cyc, p0, r0, c0, n;
        repeat (3) @(posedge pclk);
        #2;
        check("rst_busy_done_err", {61'd0, busy_o, done_o, err_o}, 64'd0);
        check("rst_bus", {60'd0, psel_o, penable_o, pwrite_o, w_ready_o}, 64'd0);
        check("rst_paddr_pwdata", {paddr_o, pwdata_o}, 64'd0);
        preset = 1'b0;

        run_xfer("T1", 32'h0000_1000, 4, 32'hD000_0000, 4'hF, 0, -1);
        run_xfer("T2", 32'h0000_2000, 2, 32'hA5A5_0000, 4'h3, 3, -1);
        run_xfer("T3", 32'h0000_1000, 4, 32'h1234_0000, 4'hF, 0, 1);
        check("T3_err_sticky", 64'(err_o), 64'd1);

        // T4: zero-length transfer
        p0 = psel_cycles;
        r0 = ready_cycles;
        base = done_cnt;
        exp_err_q.push_back(1'b0);
        do_start(32'h0000_4000, 16'd0);
        wait_done(base, cyc);
        check("T4_done_latency_le2", 64'(cyc <= 2), 64'd1);
        repeat (2) @(posedge pclk);
        #2;
        check("T4_no_psel", 64'(psel_cycles - p0), 64'd0);
        check("T4_no_wready", 64'(ready_cycles - r0), 64'd0);
        check("T4_err_cleared", 64'(err_o), 64'd0);
        $display("T4: len=0 done after %0d cycles", cyc);

        run_xfer("T5", 32'hFFFF_FFFC, 2, 32'h5555_AAAA, 4'h0, 0, -1);

        // T6a: reset during ACCESS
        run_xfer("T6pre", 32'h0000_0040, 1, 32'h0BAD_F00D, 4'hF, 0, -1);
        wait_cfg = 5;
        beat_q.push_back('{addr: 32'h2000, data: 32'hCAFE_0001, strb: 4'hF});
        beat_q.push_back('{addr: 32'h2004, data: 32'hCAFE_0002, strb: 4'hF});
        exp_q.push_back('{addr: 32'h2000, data: 32'hCAFE_0001, strb: 4'hF});
        exp_err_q.push_back(1'b0);
        do_start(32'h0000_2000, 16'd2);
        n = 0;
        while (!penable_o && n < 50) begin
            @(posedge pclk);
            #2;
            n++;
        end
        check("T6_reached_access", 64'(penable_o), 64'd1);
        @(negedge pclk);
        #2;
        preset = 1'b1;
        #1;
        check("T6_rst_ctrl", {59'd0, busy_o, done_o, err_o, psel_o, penable_o}, 64'd0);
        check("T6_rst_bus", {28'd0, pwrite_o, w_ready_o, pstrb_o, paddr_o}, 64'd0);
        check("T6_rst_pwdata", 64'(pwdata_o), 64'd0);
        beat_q.delete();
        exp_q.delete();
        exp_err_q.delete();
        wait_cfg = 0;
        base = done_cnt;
        repeat (2) @(posedge pclk);
        #2;
        preset = 1'b0;
        repeat (4) @(posedge pclk);
        #2;
        check("T6_no_done_after_rst", 64'(done_cnt - base), 64'd0);
        $display("T6a: reset mid-ACCESS, done_cnt delta=%0d", done_cnt - base);

        // T6b: start pulsed while busy must not change the running transfer
        wait_cfg = 3;
        beat_q.push_back('{addr: 32'h3000, data: 32'h7777_0000, strb: 4'hC});
        beat_q.push_back('{addr: 32'h3004, data: 32'h7777_1111, strb: 4'h5});
        exp_q.push_back('{addr: 32'h3000, data: 32'h7777_0000, strb: 4'hC});
        exp_q.push_back('{addr: 32'h3004, data: 32'h7777_1111, strb: 4'h5});
        exp_err_q.push_back(1'b0);
        c0 = consumed;
        base = done_cnt;
        do_start(32'h0000_3000, 16'd2);
        do_start(32'h0000_9000, 16'd7);
        wait_done(base, cyc);
        repeat (3) @(posedge pclk);
        #2;
        check("T6b_xfers_left", 64'(exp_q.size()), 64'd0);
        check("T6b_consumed", 64'(consumed - c0), 64'd2);
        check("T6b_done_once", 64'(done_cnt - base), 64'd1);
        check("T6b_idle", 64'(busy_o), 64'd0);
        $display("T6b: busy start ignored, consumed=%0d", consumed - c0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
